// File: rtl/stream_strip_pkg.sv
// Shared types and constants for the stream_strip datapath.
// byte_mask() zeroes every byte at position >= bcnt.
package strip_pkg;
   localparam int DATA_WIDTH    = 128;
   localparam int N_BYTES       = DATA_WIDTH / 8;
   localparam int DATA_BCNT     = $clog2(N_BYTES) + 1;
   localparam int SHIFTER_WIDTH = 2 * DATA_WIDTH;

   typedef logic [DATA_BCNT-1:0] bcnt_t;
   typedef logic [DATA_BCNT:0]   tcnt_t;

   localparam bcnt_t N_BCNT = bcnt_t'(N_BYTES);
   localparam tcnt_t T_FULL = tcnt_t'(N_BYTES);

   typedef enum logic [1:0] {
      SOP   = 2'd0,
      BODY  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   function automatic logic [DATA_WIDTH-1:0] byte_mask(input bcnt_t bcnt);
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < N_BYTES; i++) begin
         if (bcnt > bcnt_t'(i)) m[8*i +: 8] = 8'hFF;
      end
      return m;
   endfunction
endpackage

// File: rtl/stream_strip_if.sv
// Byte-enabled streaming beat: data, valid byte count, end-of-packet, vld/rdy handshake.
interface stream_strip_if;
   import strip_pkg::*;

   logic [DATA_WIDTH-1:0] dat;
   bcnt_t                 bcnt;
   logic                  eop;
   logic                  vld;
   logic                  rdy;

   modport master (output dat, bcnt, eop, vld, input rdy);
   modport slave  (input dat, bcnt, eop, vld, output rdy);
endinterface

// File: rtl/stream_strip_byte_compact_shift.sv
// Combinational: remove byte window [lo, hi), compact toward byte 0,
// then shift the compacted beat left by i_shift bytes into the merge width.
module byte_compact_shift
   import strip_pkg::*;
(
   input  logic [DATA_WIDTH-1:0]    i_dat,
   input  bcnt_t                    i_lo,
   input  bcnt_t                    i_hi,
   input  bcnt_t                    i_shift,
   output logic [SHIFTER_WIDTH-1:0] o_dat
);
   bcnt_t                 w_len;
   logic [DATA_WIDTH-1:0] w_cmp;

   assign w_len = i_hi - i_lo;

   always_comb begin
      w_cmp = '0;
      for (int j = 0; j < N_BYTES; j++) begin
         if (bcnt_t'(j) < i_lo) begin
            w_cmp[8*j +: 8] = i_dat[8*j +: 8];
         end else if ((j + int'(w_len)) < N_BYTES) begin
            w_cmp[8*j +: 8] = i_dat[8*(j + int'(w_len)) +: 8];
         end
      end
   end

   assign o_dat = {{DATA_WIDTH{1'b0}}, w_cmp} << (8 * i_shift);
endmodule

// File: rtl/stream_strip.sv
// Strips a byte window from each packet's first beat and repacks to full beats.
// One-register output stage (1-cycle latency); input stalls while output is held or during FLUSH.
module stream_strip
   import strip_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   stream_strip_if.slave  data_in,
   stream_strip_if.master data_out,
   input  logic           data_strip_en,
   input  bcnt_t          data_strip_offset,
   input  bcnt_t          data_strip_bcnt,
   output logic           data_strip_err,
   output logic           data_strip_drop
);
   state_t                   r_state,    w_state_nxt;
   bcnt_t                    r_res_cnt,  w_res_cnt_nxt;
   logic [DATA_WIDTH-1:0]    r_res_dat,  w_res_dat_nxt;
   logic [DATA_WIDTH-1:0]    r_out_dat,  w_out_dat_nxt;
   bcnt_t                    r_out_bcnt, w_out_bcnt_nxt;
   logic                     r_out_eop,  w_out_eop_nxt;
   logic                     r_out_vld,  w_out_vld_nxt;
   logic                     r_err,      w_err_nxt;
   logic                     r_drop,     w_drop_nxt;

   logic                     w_free, w_in_rdy, w_acc, w_clamp;
   bcnt_t                    w_lo, w_hi, w_k;
   tcnt_t                    w_t, w_win_end;
   logic [DATA_WIDTH-1:0]    w_in_masked;
   logic [SHIFTER_WIDTH-1:0] w_shifted, w_merge;

   assign w_free   = !r_out_vld || data_out.rdy;
   assign w_in_rdy = (r_state != FLUSH) && w_free;
   assign w_acc    = data_in.vld && w_in_rdy;

   assign w_win_end = {1'b0, data_strip_offset} + {1'b0, data_strip_bcnt};

   // Window only applies to the first beat; clamped to the beat's byte count.
   always_comb begin
      w_lo    = '0;
      w_hi    = '0;
      w_clamp = 1'b0;
      if (r_state == SOP && data_strip_en) begin
         w_clamp = (w_win_end > {1'b0, data_in.bcnt}) || (data_strip_offset >= data_in.bcnt);
         if (data_strip_offset < data_in.bcnt) begin
            w_lo = data_strip_offset;
            w_hi = (w_win_end > {1'b0, data_in.bcnt}) ? data_in.bcnt
                                                        : w_win_end[DATA_BCNT-1:0];
         end
      end
   end

   assign w_k         = data_in.bcnt - (w_hi - w_lo);
   assign w_t         = {1'b0, r_res_cnt} + {1'b0, w_k};
   assign w_in_masked = data_in.dat & byte_mask(data_in.bcnt);

   byte_compact_shift u_compact (
      .i_dat   (w_in_masked),
      .i_lo    (w_lo),
      .i_hi    (w_hi),
      .i_shift (r_res_cnt),
      .o_dat   (w_shifted)
   );

   assign w_merge = {{DATA_WIDTH{1'b0}}, r_res_dat} | w_shifted;

   always_comb begin
      w_state_nxt    = r_state;
      w_res_cnt_nxt  = r_res_cnt;
      w_res_dat_nxt  = r_res_dat;
      w_out_dat_nxt  = r_out_dat;
      w_out_bcnt_nxt = r_out_bcnt;
      w_out_eop_nxt  = r_out_eop;
      w_out_vld_nxt  = r_out_vld && !data_out.rdy;
      w_err_nxt      = 1'b0;
      w_drop_nxt     = 1'b0;
      if (r_state == FLUSH) begin
         if (w_free) begin
            w_out_dat_nxt  = r_res_dat;
            w_out_bcnt_nxt = r_res_cnt;
            w_out_eop_nxt  = 1'b1;
            w_out_vld_nxt  = 1'b1;
            w_res_cnt_nxt  = '0;
            w_res_dat_nxt  = '0;
            w_state_nxt    = SOP;
         end
      end else if (w_acc) begin
         w_err_nxt = w_clamp;
         if (!data_in.eop) begin
            w_state_nxt = BODY;
            if (w_t < T_FULL) begin
               w_res_cnt_nxt = w_t[DATA_BCNT-1:0];
               w_res_dat_nxt = w_merge[DATA_WIDTH-1:0];
            end else begin
               w_out_dat_nxt  = w_merge[DATA_WIDTH-1:0];
               w_out_bcnt_nxt = N_BCNT;
               w_out_eop_nxt  = 1'b0;
               w_out_vld_nxt  = 1'b1;
               w_res_cnt_nxt  = bcnt_t'(w_t - T_FULL);
               w_res_dat_nxt  = w_merge[SHIFTER_WIDTH-1:DATA_WIDTH];
            end
         end else if (w_t == '0) begin
            w_drop_nxt    = 1'b1;
            w_res_cnt_nxt = '0;
            w_res_dat_nxt = '0;
            w_state_nxt   = SOP;
         end else if (w_t <= T_FULL) begin
            w_out_dat_nxt  = w_merge[DATA_WIDTH-1:0];
            w_out_bcnt_nxt = w_t[DATA_BCNT-1:0];
            w_out_eop_nxt  = 1'b1;
            w_out_vld_nxt  = 1'b1;
            w_res_cnt_nxt  = '0;
            w_res_dat_nxt  = '0;
            w_state_nxt    = SOP;
         end else begin
            // Tail overflows one beat: emit a full beat now, the rest from FLUSH.
            w_out_dat_nxt  = w_merge[DATA_WIDTH-1:0];
            w_out_bcnt_nxt = N_BCNT;
            w_out_eop_nxt  = 1'b0;
            w_out_vld_nxt  = 1'b1;
            w_res_cnt_nxt  = bcnt_t'(w_t - T_FULL);
            w_res_dat_nxt  = w_merge[SHIFTER_WIDTH-1:DATA_WIDTH];
            w_state_nxt    = FLUSH;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= SOP;
         r_res_cnt  <= '0;
         r_res_dat  <= '0;
         r_out_dat  <= '0;
         r_out_bcnt <= '0;
         r_out_eop  <= 1'b0;
         r_out_vld  <= 1'b0;
         r_err      <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_res_cnt  <= w_res_cnt_nxt;
         r_res_dat  <= w_res_dat_nxt;
         r_out_dat  <= w_out_dat_nxt;
         r_out_bcnt <= w_out_bcnt_nxt;
         r_out_eop  <= w_out_eop_nxt;
         r_out_vld  <= w_out_vld_nxt;
         r_err      <= w_err_nxt;
         r_drop     <= w_drop_nxt;
      end
   end

   assign data_in.rdy     = w_in_rdy;
   assign data_out.dat    = r_out_dat;
   assign data_out.bcnt   = r_out_bcnt;
   assign data_out.eop    = r_out_eop;
   assign data_out.vld    = r_out_vld;
   assign data_strip_err  = r_err;
   assign data_strip_drop = r_drop;
endmodule

// File: tb/tb_stream_strip.sv
// Directed + randomized bench for stream_strip; expected beats come from a byte-queue model.
module tb_stream_strip;
   import strip_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n;
   logic  en;
   bcnt_t off, sb;
   logic  err, drop;

   always #5 clk = ~clk;

   stream_strip_if in_if ();
   stream_strip_if out_if ();

   stream_strip dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .data_in           (in_if),
      .data_out          (out_if),
      .data_strip_en     (en),
      .data_strip_offset (off),
      .data_strip_bcnt   (sb),
      .data_strip_err    (err),
      .data_strip_drop   (drop)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [127:0] exp_dat_q[$];
   int           exp_bcnt_q[$];
   bit           exp_eop_q[$];
   int exp_err = 0, exp_drop = 0, seen_err = 0, seen_drop = 0;
   bit sb_en = 1'b1;
   bit rnd_rdy = 1'b0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   initial begin
      out_if.rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_if.rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   logic [127:0] hold_dat;
   int           hold_bcnt;
   bit           hold_eop;
   bit           stalled = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (err)  seen_err++;
         if (drop) seen_drop++;
         if (stalled) begin
            chk("hold_vld", out_if.vld, 1);
            chk("hold_dat", out_if.dat, hold_dat);
            chk("hold_bcnt", out_if.bcnt, hold_bcnt);
            chk("hold_eop", out_if.eop, hold_eop);
         end
         stalled = out_if.vld && !out_if.rdy;
         if (stalled) begin
            hold_dat  = out_if.dat;
            hold_bcnt = out_if.bcnt;
            hold_eop  = out_if.eop;
         end
         if (out_if.vld && out_if.rdy && sb_en) begin
            vectors++;
            assert (exp_dat_q.size() > 0) else begin
               miscompares++;
               $error("FAIL unexpected_beat observed bcnt=%0d expected no beat", out_if.bcnt);
            end
            if (exp_dat_q.size() > 0) begin
               chk("beat_dat", out_if.dat, exp_dat_q.pop_front());
               chk("beat_bcnt", out_if.bcnt, exp_bcnt_q.pop_front());
               chk("beat_eop", out_if.eop, exp_eop_q.pop_front());
            end
         end
      end
   end

   // Reference: delete the clamped window from the first-beat bytes, then cut into 16-byte beats.
   task automatic model_pkt(input byte unsigned pl[$], input bit s_en, input int s_off, input int s_sb);
      byte unsigned q[$];
      int b, hi, n;
      logic [127:0] d;
      q = pl;
      b = (q.size() < 16) ? q.size() : 16;
      if (s_en) begin
         if ((s_off + s_sb > b) || (s_off >= b)) exp_err++;
         if (s_off < b) begin
            hi = (s_off + s_sb < b) ? s_off + s_sb : b;
            for (int i = s_off; i < hi; i++) q.delete(s_off);
         end
      end
      if (q.size() == 0) exp_drop++;
      while (q.size() > 0) begin
         n = (q.size() < 16) ? q.size() : 16;
         d = '0;
         for (int i = 0; i < n; i++) d[8*i +: 8] = q.pop_front();
         exp_dat_q.push_back(d);
         exp_bcnt_q.push_back(n);
         exp_eop_q.push_back(q.size() == 0);
      end
   endtask

   task automatic send_beat(input logic [127:0] d, input int bc, input bit eop,
                            input bit s_en, input int s_off, input int s_sb);
      int guard;
      guard = 0;
      @(negedge clk);
      in_if.dat  = d;
      in_if.bcnt = bcnt_t'(bc);
      in_if.eop  = eop;
      in_if.vld  = 1'b1;
      en  = s_en;
      off = bcnt_t'(s_off);
      sb  = bcnt_t'(s_sb);
      while (!in_if.rdy && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      vectors++;
      assert (guard < 1000) else begin
         miscompares++;
         $error("FAIL accept_timeout observed wait=%0d cycles expected <1000", guard);
      end
      @(posedge clk);
      #1;
      in_if.vld = 1'b0;
   endtask

   // mode 1: check output 1 cycle after each accept; mode 2: first beat silent, FLUSH blocks input.
   task automatic send_pkt(input int len, input bit s_en, input int s_off, input int s_sb, input int mode);
      byte unsigned pl[$];
      int pos, bc;
      logic [127:0] d;
      bit first;
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      model_pkt(pl, s_en, s_off, s_sb);
      pos = 0;
      first = 1'b1;
      while (pos < len) begin
         bc = (len - pos > 16) ? 16 : len - pos;
         d = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < bc; i++) d[8*i +: 8] = pl[pos + i];
         if (first) send_beat(d, bc, (pos + bc == len), s_en, s_off, s_sb);
         else send_beat(d, bc, (pos + bc == len), 1'($urandom),
                        int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         pos += bc;
         if (mode == 1) begin
            @(negedge clk);
            chk("latency_vld", out_if.vld, 1);
         end
         if (mode == 2 && first) begin
            @(negedge clk);
            chk("sop_no_out", out_if.vld, 0);
         end
         if (mode == 2 && pos == len) begin
            @(negedge clk);
            chk("flush_rdy", in_if.rdy, 0);
         end
         first = 1'b0;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_dat_q.size() != 0 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      repeat (3) @(negedge clk);
      chk("drain_left", exp_dat_q.size(), 0);
   endtask

   int d0;

   initial begin
      rst_n = 1'b0;
      in_if.vld = 1'b0; in_if.dat = '0; in_if.bcnt = '0; in_if.eop = 1'b0;
      en = 1'b0; off = '0; sb = '0;
      repeat (2) @(negedge clk);
      chk("rst_vld", out_if.vld, 0);
      chk("rst_dat", out_if.dat, 0);
      chk("rst_bcnt", out_if.bcnt, 0);
      chk("rst_eop", out_if.eop, 0);
      chk("rst_err", err, 0);
      chk("rst_drop", drop, 0);
      rst_n = 1'b1;

      send_pkt(37, 1'b0, 0, 0, 1);          // 16,16,5 pass-through
      drain();
      send_pkt(48, 1'b1, 2, 4, 0);          // -> 16,16,12
      drain();
      send_pkt(42, 1'b1, 0, 2, 2);          // -> 16,16,8 via FLUSH
      drain();

      d0 = seen_drop;
      send_pkt(6, 1'b1, 0, 6, 0);
      drain();
      chk("drop_pulse", seen_drop - d0, 1);

      d0 = seen_err;
      send_pkt(16, 1'b1, 10, 8, 0);         // clamped -> 10 bytes
      drain();
      chk("clamp_err", seen_err - d0, 1);

      d0 = seen_err;
      send_pkt(5, 1'b1, 7, 2, 0);           // offset past beat: nothing removed
      drain();
      chk("offset_err", seen_err - d0, 1);

      rnd_rdy = 1'b1;
      for (int p = 0; p < 20; p++)
         send_pkt(int'($urandom_range(1, 60)), 1'($urandom),
                  int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 0);
      drain();
      rnd_rdy = 1'b0;

      sb_en = 1'b0;
      send_beat({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 1'b1, 0, 3);
      send_beat({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", out_if.vld, 0);
      chk("mid_rst_dat", out_if.dat, 0);
      chk("mid_rst_bcnt", out_if.bcnt, 0);
      chk("mid_rst_eop", out_if.eop, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_drop", drop, 0);
      exp_dat_q.delete(); exp_bcnt_q.delete(); exp_eop_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb_en = 1'b1;
      send_pkt(20, 1'b0, 0, 0, 1);          // 16,4 with no stale residue
      drain();

      chk("err_total", seen_err, exp_err);
      chk("drop_total", seen_drop, exp_drop);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
